// File: rtl/pulse_width_detector.sv
// Per-channel high-run detector: measures how long each input stays high and
// reports qualifying runs either on release (mode 0) or on reaching threshold (mode 1).
module pulse_width_detector #(
   parameter int CH = 4,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [CW-1:0]    thr,
   input  logic [CH-1:0]    a,
   output logic [CH-1:0]    y,
   output logic [CH*CW-1:0] width_out,
   output logic [CH-1:0]    width_vld
);

   typedef enum logic [1:0] {IDLE, RUN, QUAL} state_t;

   state_t            state_q [CH];
   state_t            state_d [CH];
   logic [CW-1:0]     cnt_q   [CH];
   logic [CW-1:0]     cnt_d   [CH];
   logic [CW-1:0]     runLen  [CH];
   logic [CH-1:0]     pulsed_q, pulsed_d;
   logic [CH-1:0]     evt_q, evt_d;
   logic [CH*CW-1:0]  width_q, width_d;
   logic [CW-1:0]     thrEff;

   assign thrEff = (thr == '0) ? {{(CW-1){1'b0}}, 1'b1} : thr;

   // pulsed_q remembers that this run already reported, so a mid-run mode
   // switch can neither double-report nor drop the run's single event.
   always_comb begin
      width_d  = width_q;
      pulsed_d = pulsed_q;
      evt_d    = '0;
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         runLen[i]  = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
         if (!en) begin
            state_d[i]  = IDLE;
            cnt_d[i]    = '0;
            pulsed_d[i] = 1'b0;
         end else if (a[i]) begin
            cnt_d[i] = runLen[i];
            if (state_q[i] != QUAL && runLen[i] >= thrEff) begin
               state_d[i] = QUAL;
            end else if (state_q[i] == IDLE) begin
               state_d[i] = RUN;
            end
            if (mode && state_d[i] == QUAL && !pulsed_q[i]) begin
               evt_d[i]              = 1'b1;
               pulsed_d[i]           = 1'b1;
               width_d[i*CW +: CW]   = runLen[i];
            end
         end else begin
            if (state_q[i] == QUAL && !mode && !pulsed_q[i]) begin
               evt_d[i]            = 1'b1;
               width_d[i*CW +: CW] = cnt_q[i];
            end
            state_d[i]  = IDLE;
            cnt_d[i]    = '0;
            pulsed_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         pulsed_q <= '0;
         evt_q    <= '0;
         width_q  <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         pulsed_q <= pulsed_d;
         evt_q    <= evt_d;
         width_q  <= width_d;
      end
   end

   assign y         = evt_q;
   assign width_vld = evt_q;
   assign width_out = width_q;

endmodule

// File: tb/tb_pulse_width_detector.sv
// Self-checking bench for pulse_width_detector: a cycle model feeds a scoreboard
// queue, a vector table covers the single-run cases, hand sequences the corners.
module tb_pulse_width_detector;

   localparam int CH   = 4;
   localparam int CW   = 8;
   localparam int MAXV = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             mode = 1'b0;
   logic [CW-1:0]    thr = 8'd10;
   logic [CH-1:0]    a = '0;
   logic [CH-1:0]    y;
   logic [CH*CW-1:0] width_out;
   logic [CH-1:0]    width_vld;

   pulse_width_detector #(.CH(CH), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .thr       (thr),
      .a         (a),
      .y         (y),
      .width_out (width_out),
      .width_vld (width_vld)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0]    y;
      logic [CH*CW-1:0] w;
   } exp_t;

   typedef struct {
      int ch;
      bit mode;
      int thr;
      int highLen;
      int expPulses;
      int expWidth;
   } vec_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   pulseCnt [CH];
   int   mL [CH];
   bit   mQ [CH];
   bit   mP [CH];
   logic [CW-1:0] mW [CH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference behaviour in terms of run length, evaluated for the inputs about to be sampled.
   task automatic modelStep();
      exp_t e;
      int   thrE;
      thrE = (thr == 0) ? 1 : int'(thr);
      e.y  = '0;
      e.w  = '0;
      for (int i = 0; i < CH; i++) begin
         if (rst) begin
            mL[i] = 0; mQ[i] = 0; mP[i] = 0; mW[i] = '0;
         end else if (!en) begin
            mL[i] = 0; mQ[i] = 0; mP[i] = 0;
         end else if (a[i]) begin
            mL[i] = (mL[i] < MAXV) ? mL[i] + 1 : MAXV;
            if (!mQ[i] && mL[i] >= thrE) mQ[i] = 1;
            if (mode && mQ[i] && !mP[i]) begin
               e.y[i] = 1'b1;
               mP[i]  = 1;
               mW[i]  = CW'(mL[i]);
            end
         end else begin
            if (mQ[i] && !mode && !mP[i]) begin
               e.y[i] = 1'b1;
               mW[i]  = CW'(mL[i]);
            end
            mL[i] = 0; mQ[i] = 0; mP[i] = 0;
         end
         e.w[i*CW +: CW] = mW[i];
      end
      sbq.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sbq.pop_front();
      check("y", 64'(y), 64'(e.y));
      check("width_vld", 64'(width_vld), 64'(e.y));
      check("width_out", 64'(width_out), 64'(e.w));
      for (int i = 0; i < CH; i++) if (y[i]) pulseCnt[i]++;
   endtask

   task automatic applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic clearCounts();
      for (int i = 0; i < CH; i++) pulseCnt[i] = 0;
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{ch: 0, mode: 0, thr: 10, highLen: 10,  expPulses: 1, expWidth: 10});
      vecs.push_back('{ch: 0, mode: 0, thr: 10, highLen: 9,   expPulses: 0, expWidth: 10});
      vecs.push_back('{ch: 1, mode: 1, thr: 5,  highLen: 20,  expPulses: 1, expWidth: 5});
      vecs.push_back('{ch: 2, mode: 0, thr: 3,  highLen: 300, expPulses: 1, expWidth: 255});
      vecs.push_back('{ch: 3, mode: 0, thr: 0,  highLen: 1,   expPulses: 1, expWidth: 1});
      vecs.push_back('{ch: 3, mode: 1, thr: 0,  highLen: 3,   expPulses: 1, expWidth: 1});
      vecs.push_back('{ch: 1, mode: 0, thr: 1,  highLen: 4,   expPulses: 1, expWidth: 4});

      clearCounts();
      for (int i = 0; i < CH; i++) begin
         mL[i] = 0; mQ[i] = 0; mP[i] = 0; mW[i] = '0;
      end

      // Reset state: everything zero while rst is held.
      #2;
      check("reset_y", 64'(y), 64'd0);
      check("reset_width_out", 64'(width_out), 64'd0);
      applyStimulus();
      rst = 1'b0;
      en  = 1'b1;
      applyStimulus();

      // Single-run vectors.
      foreach (vecs[k]) begin
         clearCounts();
         mode = vecs[k].mode;
         thr  = CW'(vecs[k].thr);
         a[vecs[k].ch] = 1'b1;
         repeat (vecs[k].highLen) applyStimulus();
         a[vecs[k].ch] = 1'b0;
         repeat (2) applyStimulus();
         check($sformatf("vec%0d_pulses", k), 64'(pulseCnt[vecs[k].ch]), 64'(vecs[k].expPulses));
         check($sformatf("vec%0d_width", k), 64'(width_out[vecs[k].ch*CW +: CW]), 64'(vecs[k].expWidth));
      end

      // Simultaneous release on channels 0 and 3.
      mode = 1'b0;
      thr  = 8'd4;
      a    = 4'b1001;
      repeat (5) applyStimulus();
      a = 4'b0000;
      applyStimulus();
      check("simul_y", 64'(y), 64'b1001);
      applyStimulus();
      check("simul_y_after", 64'(y), 64'd0);

      // Back-to-back runs separated by a single low cycle.
      clearCounts();
      a[0] = 1'b1; repeat (4) applyStimulus();
      a[0] = 1'b0; applyStimulus();
      a[0] = 1'b1; repeat (4) applyStimulus();
      a[0] = 1'b0; repeat (2) applyStimulus();
      check("b2b_pulses", 64'(pulseCnt[0]), 64'd2);
      check("b2b_width", 64'(width_out[0 +: CW]), 64'd4);

      // Reset in the middle of a run at L=7, then a fresh run of 10.
      clearCounts();
      thr  = 8'd10;
      a[0] = 1'b1; repeat (7) applyStimulus();
      rst  = 1'b1; applyStimulus();
      check("rst_mid_width", 64'(width_out), 64'd0);
      rst  = 1'b0; repeat (10) applyStimulus();
      a[0] = 1'b0; repeat (2) applyStimulus();
      check("rst_mid_pulses", 64'(pulseCnt[0]), 64'd1);
      check("rst_mid_width_final", 64'(width_out[0 +: CW]), 64'd10);

      // Enable dropped on a qualified run discards it.
      clearCounts();
      thr  = 8'd3;
      a[1] = 1'b1; repeat (5) applyStimulus();
      en   = 1'b0; repeat (2) applyStimulus();
      a[1] = 1'b0;
      en   = 1'b1; repeat (2) applyStimulus();
      check("en_pulses", 64'(pulseCnt[1]), 64'd0);
      check("en_width_held", 64'(width_out[1*CW +: CW]), 64'd0);

      // Mode 1 -> 0 switch after the press event: no second event on release.
      clearCounts();
      mode = 1'b1;
      a[2] = 1'b1; repeat (4) applyStimulus();
      mode = 1'b0;
      a[2] = 1'b0; repeat (2) applyStimulus();
      check("modesw_pulses", 64'(pulseCnt[2]), 64'd1);
      check("modesw_width", 64'(width_out[2*CW +: CW]), 64'd3);

      // Threshold lowered mid-run takes effect on the next sample.
      clearCounts();
      thr  = 8'd10;
      a[3] = 1'b1; repeat (5) applyStimulus();
      thr  = 8'd3; applyStimulus();
      a[3] = 1'b0; repeat (2) applyStimulus();
      check("thrchg_pulses", 64'(pulseCnt[3]), 64'd1);
      check("thrchg_width", 64'(width_out[3*CW +: CW]), 64'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
